// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and the
//            MEM-stage data port. Optional transaction timeout: ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starved;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;
`endif

    // A waiting fetch wins a tie once it has lost STARVE_MAX grants in a row.
    assign starved = i_req && (starve_cnt_q == SW'(STARVE_MAX));

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        starve_cnt_d = starve_cnt_q;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        err_d        = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (d_req && !starved) begin
                    state_d     = GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (!i_req)
                        starve_cnt_d = '0;
                    else if (starve_cnt_q != SW'(STARVE_MAX))
                        starve_cnt_d = starve_cnt_q + SW'(1);
                end else if (i_req) begin
                    state_d      = GRANT_I;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_addr;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = '0;
                end
`ifdef ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            GRANT_I, GRANT_D: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == GRANT_I) begin
                        i_rdata_d = mem_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q)
                            d_rdata_d = mem_rdata;
                        d_ready_d = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    err_d     = 1'b1;
                    if (state_q == GRANT_I) begin
                        i_rdata_d = DW'(32'hDEADBEEF);
                        i_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q)
                            d_rdata_d = DW'(32'hDEADBEEF);
                        d_ready_d = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign stall_if  = i_req & ~i_ready_q;
    assign stall_mem = d_req & ~d_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for mem_req, lets `delay` cycles pass, then pulses ack.
    // Returns one cycle after the ack edge, i.e. in the ready cycle.
    task automatic serve(input logic [31:0] rdata, input int delay);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("mem_req_rise", mem_req, 1);
        repeat (delay) tick();
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string order;
        int    cyc;

        // Reset state
        repeat (3) tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        tick();
        check("idle_mem_req", mem_req, 0);
        check("idle_mem_addr", mem_addr, 0);

        // Single fetch
        i_req = 1'b1; i_addr = 32'h4;
        #1;
        check("fetch_stall_if_pre", stall_if, 1);
        tick();
        check("fetch_mem_req", mem_req, 1);
        check("fetch_mem_addr", mem_addr, 32'h4);
        check("fetch_mem_we", mem_we, 0);
        check("fetch_stall_if_wait", stall_if, 1);
        serve(32'h200a0005, 1);
        check("fetch_i_ready", i_ready, 1);
        check("fetch_i_rdata", i_rdata, 32'h200a0005);
        check("fetch_stall_if_done", stall_if, 0);
        check("fetch_mem_req_drop", mem_req, 0);
        i_req = 1'b0;
        tick();
        check("fetch_i_ready_pulse", i_ready, 0);
        check("fetch_i_rdata_hold", i_rdata, 32'h200a0005);

        // Stray ack in IDLE is ignored
        mem_rdata = 32'h55555555; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_i_ready", i_ready, 0);
        check("stray_d_ready", d_ready, 0);
        check("stray_i_rdata", i_rdata, 32'h200a0005);

        // Store then load
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h0C;
        serve(32'hBAD0BAD0, 1);
        check("st_d_ready", d_ready, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_wdata", mem_wdata, 32'h0C);
        check("st_mem_addr", mem_addr, 32'h8);
        check("st_d_rdata_keep", d_rdata, 32'h0);
        d_req = 1'b0;
        tick();
        check("st_d_ready_pulse", d_ready, 0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        serve(32'h0C, 0);
        check("ld_d_ready", d_ready, 1);
        check("ld_mem_we", mem_we, 0);
        check("ld_d_rdata", d_rdata, 32'h0C);
        d_req = 1'b0;
        tick();

        // Both requests held: fetch forced through after 4 data grants
        order = "DDDDIDDDDID";
        i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 11; k++) begin
            serve(32'h1000 + k, 0);
            if (order[k] == "D") begin
                check("arb_d_ready", d_ready, 1);
                check("arb_i_ready_low", i_ready, 0);
                check("arb_d_rdata", d_rdata, 32'h1000 + k);
            end else begin
                check("arb_i_ready", i_ready, 1);
                check("arb_d_ready_low", d_ready, 0);
                check("arb_i_rdata", i_rdata, 32'h1000 + k);
                check("arb_i_mem_addr", mem_addr, 32'h100);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Address change while waiting
        i_req = 1'b1; i_addr = 32'h10;
        tick();
        i_addr = 32'h20;
        serve(32'h11, 2);
        check("addrchg_i_ready", i_ready, 1);
        check("addrchg_mem_addr", mem_addr, 32'h10);
        i_req = 1'b0;
        tick();

        // Missing ack on a fetch
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        cyc = 0;
        while (mem_req === 1'b1 && cyc < 150) begin
            cyc++;
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        check("to_req_cycles", cyc, 8);
        check("to_i_ready", i_ready, 1);
        check("to_err", err, 1);
        check("to_i_rdata", i_rdata, 32'hDEADBEEF);
        i_req = 1'b0;
        tick();
        check("to_err_pulse", err, 0);
`else
        check("noto_req_held", (cyc >= 100) ? 1 : 0, 1);
        check("noto_err", err, 0);
        i_req = 1'b0;
        rst = 1'b0;
        #1;
        check("noto_rst_mem_req", mem_req, 0);
        tick();
        rst = 1'b1;
        tick();
`endif

        // Reset mid-GRANT_D
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h77;
        tick();
        check("rstg_mem_req_pre", mem_req, 1);
        rst = 1'b0;
        #1;
        check("rstg_mem_req", mem_req, 0);
        check("rstg_d_ready", d_ready, 0);
        check("rstg_i_ready", i_ready, 0);
        check("rstg_err", err, 0);
        d_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("rstg_idle_mem_req", mem_req, 0);
        check("rstg_idle_mem_addr", mem_addr, 0);
        check("rstg_idle_d_ready", d_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port unified memory between the pipeline's instruction-fetch port and its MEM-stage data port.
- Replaces the separate instruction and data arrays with one memory.
- Sequences each access through a small FSM and handles variable memory latency with a req/ack handshake.
- Generates fetch and MEM stall signals for the pipeline's stall/hazard logic.

Parameters:
- AW, 32, address width (byte address; word-aligned accesses only, bits [1:0] passed through unchanged).
- DW, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before the fetch is forced through.
- TIMEOUT, 255, max cycles in a GRANT state without mem_ack (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch read request; held until i_ready.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched instruction; valid while i_ready=1 and held afterwards.
- i_ready  out  1  one-cycle completion pulse, fetch port.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid while d_ready=1 and held afterwards.
- d_ready  out  1  one-cycle completion pulse, data port.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched store data.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle memory completion pulse.
- stall_if  out  1  combinational: i_req & ~i_ready.
- stall_mem  out  1  combinational: d_req & ~d_ready.
- err  out  1  one-cycle pulse, transaction timed out.

Behaviour:
- Reset (rst=0, async): state IDLE; all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, i_ready, d_ready, err); starve_cnt=0.
- Mid-transaction reset abandons the access. mem_req drops immediately, and the memory must tolerate this.
- FSM states: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE, request selection:
  - Only d_req: go to GRANT_D.
  - Only i_req: go to GRANT_I.
  - Both: GRANT_D, unless starve_cnt==STARVE_MAX, then GRANT_I.
  - Neither: stay in IDLE.
- On the grant edge:
  - Latch addr/we/wdata into mem_addr/mem_we/mem_wdata and set mem_req=1.
  - Fetch grants force mem_we=0.
- GRANT_x:
  - Hold mem_req and all mem_* outputs stable until mem_ack.
  - On mem_ack: clear mem_req, capture mem_rdata into i_rdata (GRANT_I) or d_rdata (GRANT_D, loads only), go to RESP.
  - Stores leave d_rdata unchanged.
- RESP:
  - Pulse i_ready or d_ready (whichever port was served) for exactly one cycle, then go to IDLE.
  - Requests are not sampled in RESP. A requester may present its next request from the RESP cycle onward; it is sampled in IDLE.
- Latency: request seen in IDLE at edge N → mem_req high from N+1 → ack at edge M → ready high for cycle M+1.
  - Minimum 3 cycles per access with single-cycle ack.
- starve_cnt:
  - +1 on each data grant made while i_req=1, saturating at STARVE_MAX.
  - Cleared on any fetch grant, or when i_req=0 in IDLE.
- Requests dropped during GRANT complete anyway; the ready pulse is still issued.
- Request/address changes while waiting are ignored; values latched at the grant are used.
- mem_ack outside a GRANT state is ignored.
- Without ARB_TIMEOUT_EN, err is tied to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and increments each GRANT cycle without mem_ack.
  - On reaching TIMEOUT: drop mem_req, load the served port's rdata with 32'hDEADBEEF (stores: rdata unchanged), go to RESP.
  - In RESP, pulse ready and err together for one cycle.
  - A mem_ack arriving in the same cycle the count reaches TIMEOUT takes precedence (normal completion, no err).
- Undefined: no counter; GRANT waits indefinitely; err=0.

Test Plan:
- Reset: rst=0 mid-GRANT_D → mem_req, d_ready, i_ready, err =0 immediately; after release, FSM in IDLE and outputs idle.
- Single fetch: i_addr=0x4, mem acks after 2 cycles with 0x200a0005 → i_ready pulses exactly one cycle with i_rdata=0x200a0005; stall_if high until then; mem_we=0.
- Store then load: d_we=1, addr=0x8, wdata=0x0C → mem_we=1, mem_wdata=0x0C, d_ready pulse, d_rdata unchanged; then load 0x8 returning 0x0C → d_rdata=0x0C.
- Simultaneous requests: both held continuously → order D,D,D,D,I,D… (fetch served after 4 data grants, STARVE_MAX=4); starve_cnt returns to 0.
- Address change while waiting: i_addr changed 0x10→0x20 during GRANT_I → mem_addr stays 0x10.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): mem_ack never asserted on fetch → mem_req drops after 8 cycles; i_ready and err pulse together; i_rdata=0xDEADBEEF. Without macro: mem_req still high after 100 cycles, err=0.
